mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Request-driven access controller that sits directly upstream of the 256×8 data memory and is its only master. It accepts one byte or 16-bit little-endian load/store request at a time from the execute stage and sequences the memory's address, active-low write-enable and write-data pins. For a 16-bit access it splits the request into two byte cycles. It returns read data with a single-cycle response pulse.

## Interface
- No parameters: data memory is fixed at 8-bit address, 8-bit data, 256 entries.
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_wide`  in  1  1 = 16-bit access, 0 = 8-bit
- `req_addr`  in  8  byte address of low byte
- `req_wdata`  in  16  store data; [7:0] only for narrow
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  16  load result
- `mem_address`  out  8  to memory `address`
- `mem_writeEn`  out  1  to memory `writeEn`; active-low, 0 = write
- `mem_write_data`  out  8  to memory `write_data`
- `mem_read_data`  in  8  from memory `read_data`; combinational

## Operation
- States: IDLE, LO, HI, RESP. Reset state IDLE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` at a rising edge, latch write, wide, addr and wdata, then go to LO.
  - Inputs are ignored in every other state.
- LO
  - `mem_address`=addr.
  - For a store: `mem_writeEn`=0 and `mem_write_data`=wdata[7:0].
  - For a load: `mem_writeEn`=1, and at the closing edge capture `mem_read_data` into the rdata[7:0] register.
  - Next state: HI if wide, else RESP.
- HI
  - `mem_address`=(addr+1) mod 256; 0xFF wraps to 0x00.
  - For a store: `mem_writeEn`=0 and `mem_write_data`=wdata[15:8].
  - For a load: capture into rdata[15:8].
  - Next state: RESP.
- RESP
  - `resp_valid`=1.
  - Next state: IDLE unconditionally. No response backpressure.
- Load result
  - Narrow load: `resp_rdata`={8'h00, byte}.
  - Wide load: {hi, lo}.
  - Stores leave the `resp_rdata` register unchanged.
- Outside LO/HI: `mem_writeEn`=1, `mem_address`=8'h00, `mem_write_data`=8'h00.
- Memory outputs are decoded from state and latched request registers only. They never depend combinationally on `req_*`.
- Reset (asynchronous, any time)
  - State returns to IDLE and `mem_writeEn` goes to 1 immediately.
  - `resp_valid`=0, `resp_rdata`=16'h0000.
  - Latched request registers are cleared to 0.
  - Reset during the HI state of a wide store leaves the low byte written and the high byte unwritten. No response is produced for that request.

## Timing
- Reset values
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0.
  - `mem_address`=0, `mem_writeEn`=1, `mem_write_data`=0.
- Accept edge E0. Write commits at the memory's edge closing each LO/HI cycle.
- Narrow access: LO in E0–E1, RESP in E1–E2. `resp_valid` is high for that one cycle.
- Wide access: LO in E0–E1, HI in E1–E2, RESP in E2–E3.
- `req_ready` returns high in the cycle after RESP.
- Peak throughput: one narrow access per 3 cycles, one wide access per 4 cycles.
- `resp_rdata` is stable from the RESP cycle until the next load's capture.

## Test plan
- Narrow store then load
  - Store 0x5A to 0x20, then load narrow 0x20.
  - Required: `mem_writeEn`=0 for exactly one cycle with address 0x20.
  - Required: `resp_rdata`=0x005A, with `resp_valid` pulsing 2 cycles after each accept.
- Wide store then load
  - Store 0xBEEF wide at 0x10, then load wide 0x10.
  - Required: memory[0x10]=0xEF and memory[0x11]=0xBE.
  - Required: `resp_rdata`=0xBEEF, with `resp_valid` 3 cycles after accept.
- Wrap-around
  - Store 0x1234 wide at 0xFF.
  - Required: memory[0xFF]=0x34 and memory[0x00]=0x12.
  - Required: a wide load at 0xFF returns 0x1234.
- Held request
  - Hold `req_valid`=1 with changing addr during LO/HI/RESP.
  - Required: no second accept until IDLE, and the latched address is unchanged.
- Reset mid wide store
  - Assert `rst` during the HI cycle of a wide store of 0xCAFE at 0x40.
  - Required: `mem_writeEn`=1 immediately and `resp_valid` never rises.
  - Required: memory[0x40]=0xFE and memory[0x41] is unchanged.
- Narrow load high byte
  - Preload memory[0x30]=0xFF and memory[0x31]=0xFF.
  - Required: a narrow load at 0x30 returns 0x00FF.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/halfword load-store requests onto a 256x8 memory
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic [7:0]  mem_address,
    output logic        mem_writeEn,
    output logic [7:0]  mem_write_data,
    input  logic [7:0]  mem_read_data
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
    state_t      state_q, state_d;
    logic        write_q, write_d, wide_q, wide_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        accept, in_lo, in_hi;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        req_ready      = state_q == IDLE;
        resp_valid     = state_q == RESP;
        in_lo          = state_q == LO;
        in_hi          = state_q == HI;
        accept         = req_valid && req_ready;
        state_d        = state_q;
        case (state_q)
            IDLE: state_d = accept ? LO : IDLE;
            LO:   state_d = wide_q ? HI : RESP;
            HI:   state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        write_d        = accept ? req_write : write_q;
        wide_d         = accept ? req_wide  : wide_q;
        addr_d         = accept ? req_addr  : addr_q;
        wdata_d        = accept ? req_wdata : wdata_q;
        mem_address    = in_lo ? addr_q : in_hi ? addr_q + 8'd1 : 8'h00;
        mem_writeEn    = !((in_lo || in_hi) && write_q);
        mem_write_data = (in_lo && write_q) ? wdata_q[7:0] : (in_hi && write_q) ? wdata_q[15:8] : 8'h00;
        rdata_d        = (in_lo && !write_q) ? (wide_q ? {rdata_q[15:8], mem_read_data} : {8'h00, mem_read_data})
                       : (in_hi && !write_q) ? {mem_read_data, rdata_q[7:0]} : rdata_q;
        resp_rdata     = rdata_q;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table, corner-case and random checks against a byte-array reference
module tb_mem_access_unit;
    logic        clk, rst, req_valid, req_ready, req_write, req_wide;
    logic [7:0]  req_addr, mem_address, mem_write_data, mem_read_data;
    logic [15:0] req_wdata, resp_rdata;
    logic        resp_valid, mem_writeEn, clr;
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_r;
    int          n_cmp, n_bad;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_writeEn(mem_writeEn),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        else if (!mem_writeEn) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];

    typedef struct {
        logic        w, wd, h;
        logic [7:0]  a;
        logic [15:0] d, r;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Issue one request from IDLE and check every cycle up to and including RESP.
    task automatic run(input logic w, input logic wd, input logic [7:0] a,
                       input logic [15:0] d, input logic hold, input logic [15:0] er);
        int lat;
        logic lo, hi, rs;
        logic [7:0] ea;
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_write = w; req_wide = wd; req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = wd ? 3 : 2;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (hold) begin
                req_addr = 8'($urandom); req_write = ~w; req_wide = ~wd; req_wdata = 16'($urandom);
            end else req_valid = 0;
            lo = c == 1; hi = wd && c == 2; rs = c == lat;
            ea = lo ? a : hi ? a + 8'd1 : 8'h00;
            #1;
            chk("ready_busy", req_ready, 0);
            chk("resp_valid", resp_valid, rs);
            chk("mem_address", mem_address, ea);
            chk("mem_writeEn", mem_writeEn, !((lo || hi) && w));
            chk("mem_write_data", mem_write_data, (lo && w) ? d[7:0] : (hi && w) ? d[15:8] : 8'h00);
            if (rs) chk("resp_rdata", resp_rdata, er);
        end
        req_valid = 0;
    endtask

    task automatic ref_op(input logic w, input logic wd, input logic [7:0] a, input logic [15:0] d);
        logic [7:0] a1;
        a1 = a + 8'd1;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (wd) ref_mem[a1] = d[15:8];
        end else exp_r = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
    endtask

    initial begin
        logic w, wd;
        logic [7:0] a;
        logic [15:0] d;
        n_cmp = 0; n_bad = 0; exp_r = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst = 1; clr = 1; req_valid = 0; req_write = 0; req_wide = 0; req_addr = 0; req_wdata = 0;
        tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h20, 16'h005A, 16'h0000};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, 16'h005A};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 8'h10, 16'hBEEF, 16'h005A};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 16'hBEEF};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0012};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 8'h30, 16'hFFFF, 16'h0012};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 8'h30, 16'h0000, 16'h00FF};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 8'h10, 16'h0000, 16'hBEEF};
        tv[10] = '{1'b1, 1'b0, 1'b1, 8'h20, 16'h0077, 16'hBEEF};
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 16'h0000);
        chk("rst_addr", mem_address, 8'h00);
        chk("rst_we", mem_writeEn, 1);
        chk("rst_wdata", mem_write_data, 8'h00);
        rst = 0; clr = 0;

        for (int i = 0; i < 11; i++) begin
            run(tv[i].w, tv[i].wd, tv[i].a, tv[i].d, tv[i].h, tv[i].r);
            ref_op(tv[i].w, tv[i].wd, tv[i].a, tv[i].d);
        end
        chk("mem10", mem[8'h10], 8'hEF);
        chk("mem11", mem[8'h11], 8'hBE);
        chk("memFF", mem[8'hFF], 8'h34);
        chk("mem00", mem[8'h00], 8'h12);
        chk("mem20", mem[8'h20], 8'h77);

        @(negedge clk);
        req_valid = 1; req_write = 1; req_wide = 1; req_addr = 8'h40; req_wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rs_lo_we", mem_writeEn, 0);
        chk("rs_lo_data", mem_write_data, 8'hFE);
        @(negedge clk);
        chk("rs_hi_we", mem_writeEn, 0);
        chk("rs_hi_addr", mem_address, 8'h41);
        rst = 1;
        #1;
        chk("rs_we_now", mem_writeEn, 1);
        chk("rs_addr_now", mem_address, 8'h00);
        chk("rs_ready_now", req_ready, 1);
        chk("rs_rdata_now", resp_rdata, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rs_no_resp", resp_valid, 0);
        end
        chk("mem40", mem[8'h40], 8'hFE);
        chk("mem41", mem[8'h41], ref_mem[8'h41]);
        ref_mem[8'h40] = 8'hFE;
        exp_r = 16'h0000;

        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom); wd = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            d = 16'($urandom);
            if (!w) ref_op(w, wd, a, d);
            run(w, wd, a, d, 1'($urandom_range(0, 3) == 0), exp_r);
            if (w) ref_op(w, wd, a, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
        chk("final_mem_FF", mem[8'hFF], ref_mem[8'hFF]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
